// File: rtl/gyro_frame_serdes.sv
// Frame-aligned serializer/deserializer for the gyro link: MSB-first TX frames with DSYNC, multi-lane RX into a small FIFO.
// Optional underrun counter enabled by defining GYRO_FRAME_SERDES_UNDERRUN_EN.
module gyro_frame_serdes #(
  parameter int TX_WIDTH = 48,
  parameter int RX_WIDTH = 16,
  parameter int RX_LANES = 1,
  parameter int RX_DPWR  = 2
) (
  input  logic                         txclk,
  input  logic                         tx_rstn,
  input  logic                         enable,
  input  logic                         out_en,
  input  logic                         in_en,
  input  logic                         loopback,
  input  logic                         clear,
  input  logic [TX_WIDTH-1:0]          tx_tdata,
  input  logic                         tx_tvalid,
  output logic                         tx_tready,
  input  logic [RX_LANES-1:0]          drx,
  output logic [RX_LANES*RX_WIDTH-1:0] rx_tdata,
  output logic                         rx_tvalid,
  input  logic                         rx_tready,
  output logic                         rx_tlast,
  output logic                         dtx,
  output logic                         dsync,
  output logic                         mck_en,
`ifdef GYRO_FRAME_SERDES_UNDERRUN_EN
  output logic [15:0]                  underrun_cnt,
`endif
  output logic                         rx_overflow
);

  localparam int FW    = $clog2(TX_WIDTH);
  localparam int WW    = $clog2(RX_WIDTH);
  localparam int DEPTH = 1 << RX_DPWR;
  localparam int PW    = RX_DPWR + 1;
  localparam int DW    = RX_LANES * RX_WIDTH;
  localparam logic [FW-1:0] FRAME_LAST = FW'(TX_WIDTH - 1);
  localparam logic [WW-1:0] WORD_LAST  = WW'(RX_WIDTH - 1);

  logic [FW-1:0]       frame_cnt_q, frame_cnt_d;
  logic [WW-1:0]       word_cnt_q, word_cnt_d;
  logic [TX_WIDTH-1:0] shift_q, shift_d;
  logic                tx_active_q, tx_active_d;
  logic                frame_end, word_end, tx_accept;

  logic [RX_LANES-1:0][RX_WIDTH-1:0] rx_sr_q, rx_word;
  logic [RX_LANES-1:0] rx_src;
  logic [DW:0]         mem_q [DEPTH];
  logic [DW:0]         head;
  logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic                full, push, pop, push_ok, drop;
  logic                rx_overflow_q, rx_overflow_d;

  assign frame_end = (frame_cnt_q == FRAME_LAST);
  assign word_end  = (word_cnt_q == WORD_LAST);
  assign tx_tready = out_en & frame_end;
  assign tx_accept = tx_tvalid & tx_tready;
  assign dsync     = frame_end;
  assign dtx       = shift_q[TX_WIDTH-1] & tx_active_q & enable;
  assign mck_en    = enable & (tx_active_q | ~out_en);

  // TX: reload at the frame boundary, otherwise shift while a word is in flight
  always_comb begin
    frame_cnt_d = frame_end ? '0 : frame_cnt_q + 1'b1;
    word_cnt_d  = word_end ? '0 : word_cnt_q + 1'b1;
    shift_d     = shift_q;
    tx_active_d = tx_active_q;
    if (frame_end) begin
      tx_active_d = tx_accept;
      if (tx_accept) shift_d = tx_tdata;
    end else if (tx_active_q) begin
      shift_d = {shift_q[TX_WIDTH-2:0], 1'b0};
    end
  end

  // RX: the pushed word includes the bit sampled in the boundary cycle itself
  assign rx_src = loopback ? {RX_LANES{dtx}} : drx;
  always_comb begin
    for (int k = 0; k < RX_LANES; k++) begin
      rx_word[k] = {rx_sr_q[k][RX_WIDTH-2:0], rx_src[k]};
    end
  end

  assign rx_tvalid = (wr_q != rd_q);
  assign full      = ((wr_q - rd_q) == PW'(DEPTH));
  assign pop       = rx_tvalid & rx_tready;
  assign push      = word_end & in_en;
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign head      = mem_q[rd_q[RX_DPWR-1:0]];
  assign {rx_tlast, rx_tdata} = rx_tvalid ? head : '0;
  assign rx_overflow = rx_overflow_q;

  always_comb begin
    wr_d          = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d          = pop ? rd_q + 1'b1 : rd_q;
    rx_overflow_d = rx_overflow_q;
    if (drop) rx_overflow_d = 1'b1;
    else if (clear) rx_overflow_d = 1'b0;
  end

  always_ff @(posedge txclk or negedge tx_rstn) begin
    if (!tx_rstn) begin
      frame_cnt_q   <= '0;
      word_cnt_q    <= '0;
      shift_q       <= '0;
      tx_active_q   <= 1'b0;
      wr_q          <= '0;
      rd_q          <= '0;
      rx_overflow_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      word_cnt_q    <= word_cnt_d;
      shift_q       <= shift_d;
      tx_active_q   <= tx_active_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      rx_overflow_q <= rx_overflow_d;
    end
  end

  // Data-only storage; validity comes from the reset pointers
  always_ff @(posedge txclk) begin
    rx_sr_q <= rx_word;
    if (push_ok) mem_q[wr_q[RX_DPWR-1:0]] <= {frame_end, rx_word};
  end

`ifdef GYRO_FRAME_SERDES_UNDERRUN_EN
  logic [15:0] underrun_q, underrun_d;
  logic        underrun_evt;

  assign underrun_evt = frame_end & out_en & tx_active_q & ~tx_tvalid;
  assign underrun_cnt = underrun_q;

  always_comb begin
    underrun_d = underrun_q;
    if (clear) underrun_d = underrun_evt ? 16'd1 : 16'd0;
    else if (underrun_evt && underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
  end

  always_ff @(posedge txclk or negedge tx_rstn) begin
    if (!tx_rstn) underrun_q <= '0;
    else          underrun_q <= underrun_d;
  end
`endif

endmodule

// File: tb/tb_gyro_frame_serdes.sv
// Self-checking bench for gyro_frame_serdes (two RX lanes) against a frame-level reference model.
module tb_gyro_frame_serdes;

  logic        txclk = 1'b0;
  logic        tx_rstn, enable, out_en, in_en, loopback, clear;
  logic [47:0] tx_tdata;
  logic        tx_tvalid, tx_tready;
  logic [1:0]  drx;
  logic [31:0] rx_tdata;
  logic        rx_tvalid, rx_tready, rx_tlast;
  logic        dtx, dsync, mck_en, rx_overflow;
`ifdef GYRO_FRAME_SERDES_UNDERRUN_EN
  logic [15:0] underrun_cnt;
`endif

  always #5 txclk = ~txclk;

  gyro_frame_serdes #(.TX_WIDTH(48), .RX_WIDTH(16), .RX_LANES(2), .RX_DPWR(2)) dut (
    .txclk(txclk), .tx_rstn(tx_rstn), .enable(enable), .out_en(out_en), .in_en(in_en),
    .loopback(loopback), .clear(clear), .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid),
    .tx_tready(tx_tready), .drx(drx), .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid),
    .rx_tready(rx_tready), .rx_tlast(rx_tlast), .dtx(dtx), .dsync(dsync), .mck_en(mck_en),
`ifdef GYRO_FRAME_SERDES_UNDERRUN_EN
    .underrun_cnt(underrun_cnt),
`endif
    .rx_overflow(rx_overflow)
  );

  typedef struct { logic [31:0] d; logic l; } ent_t;

  int          errors = 0;
  int          checks = 0;
  int          m_cnt;
  bit          m_act, m_ovf;
  logic [47:0] m_word;
  logic [15:0] m_urun;
  logic [15:0] lanebits [2];
  ent_t        mq [$];

  localparam logic [47:0] WORD = 48'hA5A5_0F0F_FFFF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_dtx();
    return m_act && enable && m_word[47 - m_cnt];
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_act = 0; m_word = '0; m_ovf = 0; m_urun = '0;
    mq.delete();
  endfunction

  // Advances the reference by one clock using the inputs held across that edge
  function automatic void model_edge();
    logic [1:0] src;
    bit pop, push, full, inc;
    ent_t e;
    src = loopback ? {2{exp_dtx()}} : drx;
    for (int k = 0; k < 2; k++) lanebits[k][m_cnt % 16] = src[k];
    full = (mq.size() == 4);
    pop  = (mq.size() > 0) && rx_tready;
    push = ((m_cnt % 16) == 15) && in_en;
    if (pop) void'(mq.pop_front());
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) e.d[k*16 + 15 - i] = lanebits[k][i];
    e.l = (m_cnt == 47);
    if (push && (!full || pop)) mq.push_back(e);
    if (push && full && !pop) m_ovf = 1;
    else if (clear) m_ovf = 0;
    inc = (m_cnt == 47) && out_en && m_act && !tx_tvalid;
    if (clear) m_urun = inc ? 16'd1 : 16'd0;
    else if (inc && m_urun != 16'hFFFF) m_urun = m_urun + 16'd1;
    if (m_cnt == 47) begin
      m_act = out_en && tx_tvalid;
      if (m_act) m_word = tx_tdata;
    end
    m_cnt = (m_cnt + 1) % 48;
  endfunction

  task automatic check_all();
    chk("dsync", dsync, m_cnt == 47);
    chk("tx_tready", tx_tready, out_en && m_cnt == 47);
    chk("dtx", dtx, exp_dtx());
    chk("mck_en", mck_en, enable && (m_act || !out_en));
    chk("rx_tvalid", rx_tvalid, mq.size() > 0);
    chk("rx_tdata", rx_tdata, (mq.size() > 0) ? mq[0].d : 32'h0);
    chk("rx_tlast", rx_tlast, (mq.size() > 0) ? mq[0].l : 1'b0);
    chk("rx_overflow", rx_overflow, m_ovf);
`ifdef GYRO_FRAME_SERDES_UNDERRUN_EN
    chk("underrun_cnt", underrun_cnt, m_urun);
`endif
  endtask

  task automatic step();
    @(posedge txclk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int first, pulses;
    logic [47:0] dv;
    logic [15:0] gw [$];
    logic        gl [$];

    tx_rstn = 0; enable = 0; out_en = 0; in_en = 0; loopback = 0; clear = 0;
    tx_tdata = '0; tx_tvalid = 0; drx = '0; rx_tready = 0;
    model_reset();
    #2;
    chk("rst_dtx", dtx, 0); chk("rst_dsync", dsync, 0); chk("rst_mck", mck_en, 0);
    chk("rst_rvalid", rx_tvalid, 0); chk("rst_ovf", rx_overflow, 0); chk("rst_tready", tx_tready, 0);
    #20;
    tx_rstn = 1; enable = 1;

    // Idle link with the output channel stopped
    first = -1; pulses = 0;
    for (int i = 1; i <= 96; i++) begin
      drx = 2'($urandom);
      step();
      if (dsync) begin pulses++; if (first < 0) first = i; end
    end
    chk("first_dsync", first, 47);
    chk("dsync_pulses", pulses, 2);

    // Continuous fixed word with loopback
    out_en = 1; tx_tdata = WORD; tx_tvalid = 1; loopback = 1; rx_tready = 1;
    for (int i = 0; i < 48; i++) step();
    in_en = 1; dv = '0;
    for (int i = 0; i < 144; i++) begin
      step();
      if (i >= 48 && i < 96) dv[47 - m_cnt] = dtx;
      if (rx_tvalid && rx_tready) begin gw.push_back(rx_tdata[15:0]); gl.push_back(rx_tlast); end
    end
    chk("dtx_frame", dv, WORD);
    if (gw.size() >= 3) begin
      chk("lb_w0", gw[0], 16'hA5A5); chk("lb_l0", gl[0], 0);
      chk("lb_w1", gw[1], 16'h0F0F); chk("lb_l1", gl[1], 0);
      chk("lb_w2", gw[2], 16'hFFFF); chk("lb_l2", gl[2], 1);
    end else chk("lb_count", gw.size(), 3);

    // FIFO overflow on two lanes, then clear
    loopback = 0; in_en = 0;
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 48 && m_cnt != 0; i++) step();
    rx_tready = 0; in_en = 1;
    for (int i = 0; i < 96; i++) begin drx = 2'($urandom); tx_tdata = {16'($urandom), $urandom}; step(); end
    chk("ovf_set", rx_overflow, 1);
    in_en = 0; clear = 1; step(); clear = 0;
    chk("ovf_clr", rx_overflow, 0);
    chk("ovf_keep", rx_tvalid, 1);
    rx_tready = 1;
    for (int i = 0; i < 6; i++) step();

    // One word then an underrun
    clear = 1; step(); clear = 0;
    tx_tvalid = 1; tx_tdata = {16'($urandom), $urandom};
    for (int i = 0; i < 48 && m_cnt != 47; i++) step();
    step();
    tx_tvalid = 0;
    for (int i = 0; i < 58; i++) step();
    chk("idle_mck", mck_en, 0);
    for (int i = 0; i < 48; i++) step();
`ifdef GYRO_FRAME_SERDES_UNDERRUN_EN
    chk("urun_one", underrun_cnt, 16'd1);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drx = 2'($urandom); rx_tready = ($urandom_range(0, 3) != 0); in_en = ($urandom_range(0, 7) != 0);
      enable = ($urandom_range(0, 15) != 0); out_en = ($urandom_range(0, 15) != 0);
      tx_tvalid = ($urandom_range(0, 5) != 0); tx_tdata = {16'($urandom), $urandom};
      clear = ($urandom_range(0, 49) == 0);
      if (i % 100 == 0) loopback = $urandom_range(0, 1);
      step();
    end

    // Reset mid-word
    enable = 1; out_en = 1; tx_tvalid = 1; in_en = 1; rx_tready = 0; loopback = 0; clear = 0;
    tx_tdata = 48'hFFFF_FFFF_FFFF;
    for (int i = 0; i < 100 && !(m_cnt == 20 && m_act); i++) step();
    tx_rstn = 0;
    #1;
    chk("mr_dtx", dtx, 0); chk("mr_dsync", dsync, 0); chk("mr_rvalid", rx_tvalid, 0);
    model_reset();
    #20;
    tx_rstn = 1;
    first = -1;
    for (int i = 1; i <= 60; i++) begin step(); if (dsync && first < 0) first = i; end
    chk("mr_first_dsync", first, 47);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
